// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and border test for the LBP host responder.
package lbp_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = AW - XW;

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [XW-1:0] COL_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST  = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // IMG_W is a power of two, so column/row are plain bit fields of the address.
  function automatic logic is_border(input logic [AW-1:0] addr);
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    col = addr[XW-1:0];
    row = addr[AW-1:XW];
    return (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
  endfunction

endpackage

// File: rtl/lbp_img_ram.sv
// Simple RAM: one synchronous write port, one asynchronous (same-cycle) read port.
module lbp_img_ram #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lbp_gray_host.sv
// Host responder for the LBP engine: loads the gray image, serves engine reads,
// captures engine results and streams the result image out with a zeroed border.
//
// state | meaning
// LOAD  | accepting raster pixels into the image RAM
// SERVE | image ready; engine reads gray data and writes results
// DUMP  | streaming the result image, one beat per accepted handshake
// DONE  | dump complete; idle until reset
module lbp_gray_host
  import lbp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW:0]   lbp_data,
  input  logic          finish,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_last,
  output logic          done,
  output logic          lbp_ovf
);

  state_e        state_q;
  logic [AW-1:0] ld_cnt_q;
  logic [AW-1:0] dp_cnt_q;
  logic          pix_ready_q;
  logic          gray_ready_q;
  logic          res_valid_q;
  logic [DW-1:0] res_data_q;
  logic          res_last_q;
  logic          done_q;
  logic          ovf_q;

  logic          img_we;
  logic          res_we;
  logic          advance;
  logic [AW-1:0] dp_inc;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] res_rdata;
  logic [DW-1:0] res_data_d;

  logic          unused_gray_req;
  assign unused_gray_req = gray_req;

  assign img_we  = (state_q == LOAD) && pix_valid && pix_ready_q;
  assign res_we  = (state_q == SERVE) && lbp_valid;
  assign advance = res_valid_q && res_ready;
  assign dp_inc  = dp_cnt_q + AW'(1);
  // Look one address ahead on an accepted beat so the next beat is ready without a bubble.
  assign rd_addr = advance ? dp_inc : dp_cnt_q;

  always_comb begin
    res_data_d = res_rdata;
    if (is_border(rd_addr)) res_data_d = '0;
  end

  lbp_img_ram #(.AW(AW), .DW(DW)) img_ram (
    .clk     (clk),
    .we_i    (img_we),
    .waddr_i (ld_cnt_q),
    .wdata_i (pix_data),
    .raddr_i (gray_addr),
    .rdata_o (gray_data)
  );

  lbp_img_ram #(.AW(AW), .DW(DW)) res_ram (
    .clk     (clk),
    .we_i    (res_we),
    .waddr_i (lbp_addr),
    .wdata_i (lbp_data[DW-1:0]),
    .raddr_i (rd_addr),
    .rdata_o (res_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD;
      ld_cnt_q     <= '0;
      dp_cnt_q     <= '0;
      pix_ready_q  <= 1'b1;
      gray_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_last_q   <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (img_we) begin
            if (ld_cnt_q == LAST_ADDR) begin
              state_q      <= SERVE;
              pix_ready_q  <= 1'b0;
              gray_ready_q <= 1'b1;
            end else begin
              ld_cnt_q <= ld_cnt_q + AW'(1);
            end
          end
        end
        SERVE: begin
          if (lbp_valid && lbp_data[DW]) ovf_q <= 1'b1;
          if (finish) begin
            state_q      <= DUMP;
            gray_ready_q <= 1'b0;
            dp_cnt_q     <= '0;
          end
        end
        DUMP: begin
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
            res_data_q  <= res_data_d;
            res_last_q  <= (dp_cnt_q == LAST_ADDR);
          end else if (res_ready) begin
            if (res_last_q) begin
              res_valid_q <= 1'b0;
              res_data_q  <= '0;
              res_last_q  <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              dp_cnt_q   <= dp_inc;
              res_data_q <= res_data_d;
              res_last_q <= (dp_inc == LAST_ADDR);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_ready  = pix_ready_q;
  assign gray_ready = gray_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_last   = res_last_q;
  assign done       = done_q;
  assign lbp_ovf    = ovf_q;

endmodule

// File: tb/tb_lbp_gray_host.sv
// Directed bench for lbp_gray_host: load, engine writes, dump with stalls, mid-dump reset.
module tb_lbp_gray_host;
  import lbp_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW:0]   lbp_data;
  logic          finish;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_last;
  logic          done;
  logic          lbp_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lbp_gray_host dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last),
    .done       (done),
    .lbp_ovf    (lbp_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected dump value for addresses the bench knows; unwritten interior pixels are skipped.
  function automatic bit exp_beat(input int a, output logic [7:0] v);
    int row, col;
    row = a / IMG_W;
    col = a % IMG_W;
    v = 8'h00;
    if (row == 0 || row == IMG_H - 1 || col == 0 || col == IMG_W - 1) return 1'b1;
    if (a == 129) begin v = 8'h5A; return 1'b1; end
    if (a == 200) begin v = 8'h11; return 1'b1; end
    if (a == 300) begin v = 8'h00; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic load_image();
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = i[7:0];
      finish    = (i == 5);
      lbp_valid = (i == 6);
      lbp_addr  = AW'(129);
      lbp_data  = 9'h0FF;
      if (i == NPIX - 1) chk("pix_ready_in_load", pix_ready, 1);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    finish    = 1'b0;
    lbp_valid = 1'b0;
    chk("pix_ready_after_load", pix_ready, 0);
    chk("gray_ready_after_load", gray_ready, 1);
  endtask

  task automatic engine_write(input int a, input logic [8:0] d, input bit fin);
    @(negedge clk);
    lbp_valid = 1'b1;
    lbp_addr  = AW'(a);
    lbp_data  = d;
    finish    = fin;
    @(negedge clk);
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic start_dump();
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    chk("gray_ready_drop", gray_ready, 0);
    chk("res_valid_entry", res_valid, 0);
  endtask

  // Consumes beats until max_beats are accepted; returns at the negedge of the last acceptance.
  task automatic run_dump(input int max_beats, input bit stall, output int beats);
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [7:0]    ev;
    bit            r;
    int            cyc;
    beats      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    cyc        = 0;
    while (beats < max_beats && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_data", res_data, prev_data);
        chk("stall_last", res_last, prev_last);
      end
      if (res_valid) begin
        r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        res_ready = r;
        if (r) begin
          if (exp_beat(beats, ev)) chk($sformatf("beat_%0d", beats), res_data, ev);
          chk($sformatf("last_%0d", beats), res_last, (beats == NPIX - 1));
          beats++;
        end
        prev_stall = !r;
        prev_data  = res_data;
        prev_last  = res_last;
      end else begin
        res_ready  = 1'b0;
        prev_stall = 1'b0;
      end
    end
    if (beats != max_beats) chk("dump_timeout", beats, max_beats);
  endtask

  initial begin
    int b;
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    gray_req  = 1'b0;
    gray_addr = '0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_data  = '0;
    finish    = 1'b0;
    res_ready = 1'b0;
    #1;
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_gray_ready", gray_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_done", done, 0);
    chk("rst_lbp_ovf", lbp_ovf, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Load with no gaps, then same-cycle gray reads.
    load_image();
    gray_req  = 1'b1;
    gray_addr = AW'(300);   #1 chk("gray_300", gray_data, 44);
    gray_addr = AW'(0);     #1 chk("gray_0", gray_data, 0);
    gray_addr = AW'(257);   #1 chk("gray_257", gray_data, 1);
    gray_addr = AW'(16383); #1 chk("gray_16383", gray_data, 8'hFF);
    gray_req  = 1'b0;

    // Engine writes, overflow write, border write, write coincident with finish.
    engine_write(129, 9'h05A, 1'b0);
    chk("ovf_clear", lbp_ovf, 0);
    engine_write(300, 9'h100, 1'b0);
    chk("ovf_set", lbp_ovf, 1);
    engine_write(128, 9'h077, 1'b0);
    engine_write(200, 9'h011, 1'b1);
    chk("gray_ready_drop", gray_ready, 0);
    chk("res_valid_entry", res_valid, 0);

    // Full dump with random backpressure.
    run_dump(NPIX, 1'b1, b);
    @(negedge clk);
    res_ready = 1'b0;
    chk("beat_count", b, NPIX);
    chk("done_set", done, 1);
    chk("res_valid_done", res_valid, 0);
    chk("res_last_done", res_last, 0);
    chk("pix_ready_done", pix_ready, 0);
    chk("ovf_sticky", lbp_ovf, 1);
    repeat (3) @(negedge clk);
    chk("done_sticky", done, 1);

    // Reload, dump to beat 5000, reset in the middle of the stream.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    chk("rst2_done", done, 0);
    load_image();
    start_dump();
    run_dump(5000, 1'b0, b);
    @(negedge clk);
    chk("valid_before_rst", res_valid, 1);
    reset     = 1'b1;
    res_ready = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_pix_ready", pix_ready, 1);
    chk("midrst_gray_ready", gray_ready, 0);
    @(negedge clk);
    reset = 1'b0;

    // New run must dump from beat 0 again.
    load_image();
    start_dump();
    run_dump(130, 1'b0, b);
    res_ready = 1'b0;
    chk("rerun_beats", b, 130);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
